// File: rtl/tue_stream_fifo.sv
// tue_stream_fifo: valid/ready elastic FIFO used as the loopback stage of
// tue-based verification environments.
// Optional feature macro: TUE_STREAM_FIFO_COUNT_EN exposes the occupancy
// counter on output port `count`; without it the port is absent.
// in_ready is registered from the next-state occupancy, so out_ready never
// reaches in_ready combinationally.
module tue_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef TUE_STREAM_FIFO_COUNT_EN
  ,
  output logic [CW-1:0]         count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         occ_next;
  logic                  in_ready_q;
  logic                  push;
  logic                  pop;

  assign push      = in_valid && in_ready_q;
  assign pop       = (occ != '0) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (occ != '0);
  // Storage is not reset, so mask the head while empty to keep out_data at 0.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef TUE_STREAM_FIFO_COUNT_EN
  assign count = occ;
`endif

  // Next occupancy: flush wins, push+pop together leave it unchanged.
  always_comb begin
    occ_next = occ;
    if (flush) begin
      occ_next = '0;
    end else if (push && !pop) begin
      occ_next = occ + CW'(1);
    end else if (pop && !push) begin
      occ_next = occ - CW'(1);
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      occ        <= occ_next;
      in_ready_q <= (occ_next != CW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Beat storage; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifndef SYNTHESIS
  // Producer must hold in_valid until the beat is accepted.
  a_in_valid_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready && !flush) |=> (!rst_n || in_valid)
  ) else $error("in_valid dropped before acceptance");

  // Head beat stays put while the consumer stalls.
  a_out_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (!rst_n || (out_valid && $stable(out_data)))
  ) else $error("out_data changed while stalled");

  // Occupancy never exceeds capacity.
  a_occ_bound : assert property (
    @(posedge clk) disable iff (!rst_n) occ <= CW'(DEPTH)
  ) else $error("occupancy overflow");
`endif

endmodule

// File: tb/tb_tue_stream_fifo.sv
// Scoreboard bench for tue_stream_fifo (DATA_WIDTH=32, DEPTH=8).
module tb_tue_stream_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef TUE_STREAM_FIFO_COUNT_EN
  logic [CW-1:0] count;
`endif

  tue_stream_fifo #(.DATA_WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef TUE_STREAM_FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  logic         sb_pop;
  logic         sb_have;
  logic [W-1:0] sb_got;
  logic [W-1:0] sb_exp;

  // Records the handshakes of the coming edge into the scoreboard, then
  // advances to the next falling edge. Called with inputs already driven.
  task automatic step();
    sb_pop  = out_valid && out_ready && !flush;
    sb_got  = out_data;
    sb_have = 1'b0;
    sb_exp  = '0;
    if (sb_pop && q.size() > 0) begin
      sb_have = 1'b1;
      sb_exp  = q.pop_front();
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) q.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rel_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", out_data); end
    step();
    n_cmp++; if (sb_pop !== 1'b1 || !sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL single_pop: got %h expected %h", sb_got, sb_exp); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_fill_stall();
    int nxt;
    int got_n;
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
    end
    in_data = W'(8);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got %b expected 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b expected 0", c, in_ready); end
      n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL stall_head[%0d]: got %h expected 0", c, out_data); end
    end
    nxt = 8; got_n = 0; out_ready = 1'b1;
    for (int c = 0; c < 60 && (nxt < 10 || q.size() > 0); c++) begin
      logic acc;
      acc = in_valid && in_ready;
      step();
      if (sb_pop) begin
        got_n++;
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL fill_order: got %h expected %h", sb_got, sb_exp); end
      end
      if (acc) begin
        nxt++;
        if (nxt < 10) in_data = W'(nxt);
        else in_valid = 1'b0;
      end
    end
    n_cmp++; if (got_n != 10) begin n_bad++; $display("FAIL fill_beats: got %0d expected 10", got_n); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fill_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int nxt;
    int pops;
    nxt = 0; pops = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 20 && in_ready; c++) begin
      in_data = 32'h100 + W'(nxt);
      step();
      nxt++;
    end
    in_data = 32'h100 + W'(nxt);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      logic acc;
      acc = in_valid && in_ready;
      step();
      if (sb_pop) begin
        pops++;
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL b2b_order: got %h expected %h", sb_got, sb_exp); end
      end
      if (acc) begin nxt++; in_data = 32'h100 + W'(nxt); end
    end
    n_cmp++; if (pops != 100) begin n_bad++; $display("FAIL b2b_rate: got %0d expected 100", pops); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      step();
      if (sb_pop) begin
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL b2b_drain: got %h expected %h", sb_got, sb_exp); end
      end
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_left: got %0d beats expected 0", q.size()); end
  endtask

  task automatic test_steady();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + W'(i);
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = 32'h203 + W'(c);
      step();
      n_cmp++; if (!sb_pop || !sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL steady_order[%0d]: got %h expected %h", c, sb_got, sb_exp); end
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL steady_flags[%0d]: got %b%b expected 11", c, out_valid, in_ready); end
`ifdef TUE_STREAM_FIFO_COUNT_EN
      n_cmp++; if (count !== CW'(3)) begin n_bad++; $display("FAIL steady_count[%0d]: got %0d expected 3", c, count); end
`endif
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      step();
      if (sb_pop) begin
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL steady_drain: got %h expected %h", sb_got, sb_exp); end
      end
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL steady_left: got %0d beats expected 0", q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + W'(i);
      step();
    end
    flush = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL flush_data: got %h expected 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
`ifdef TUE_STREAM_FIFO_COUNT_EN
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", count); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_idle[%0d]: got %b expected 0", c, out_valid); end
    end
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      step();
      if (sb_pop) begin
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL flush_next: got %h expected %h", sb_got, sb_exp); end
      end
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_left: got %0d beats expected 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h400 + W'(i);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL arst_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL arst_data: got %h expected 0", out_data); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_idle[%0d]: got %b expected 0", c, out_valid); end
    end
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      step();
      if (sb_pop) begin
        n_cmp++; if (!sb_have || sb_got !== sb_exp) begin n_bad++; $display("FAIL arst_next: got %h expected %h", sb_got, sb_exp); end
      end
    end
    n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_left: got %0d beats expected 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_back_to_back();
    test_steady();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
